multi_tick_generator: RTL and testbench
=======================================

Name: multi_tick_generator

Overview:
- Parametrised, multi-channel successor to the fixed 1 Hz / 4 kHz seven-segment divider.
- Generates NUM_CH independent single-cycle tick pulses from one clock, each with its own divisor.
- Divisors have parameter reset values and can be reprogrammed at runtime without glitches.
- Feeds the display scan, the game timer and shot-timing logic, which use the ticks as clock enables.

Parameters:
NUM_CH, 4, number of tick channels (1..16)
CNT_W, 32, divisor and counter width in bits
DIV_INIT, {32'd1_000_000, 32'd100_000, 32'd25_000, 32'd100_000_000}, packed NUM_CH*CNT_W reset divisors; channel 0 in the LSBs
CH_W, (NUM_CH>1 ? $clog2(NUM_CH) : 1), channel-select width (derived; do not override)

Ports:
clk  input  1  system clock (100 MHz nominal)
rst  input  1  asynchronous, active-high reset
en  input  1  global run; low freezes all counters
sync  input  1  synchronous restart of all channels
wr_en  input  1  divisor write strobe
wr_ch  input  CH_W  channel index for the write
wr_div  input  CNT_W  new divisor for the write
tick  output  NUM_CH  one-cycle pulse per channel period
wr_err  output  1  one-cycle pulse when a write targets an invalid channel

Behaviour:
- Per-channel registers: cnt, active_div, pend_div.
- Reset (async, immediate on rst rising):
  - cnt=0, tick=0, wr_err=0.
  - active_div = pend_div = DIV_INIT slice for that channel.
  - Release is taken on the next clk edge.
- Divisor semantics: N gives a period of N cycles. N=1 holds tick high continuously. N=0 disables the channel (cnt held at 0, tick=0).
- Edge priority, per channel and per edge: sync > en-low > count.
- sync=1:
  - cnt<=0, tick<=0, active_div<=pend_div.
  - Applies to all channels regardless of en.
- sync=0, en=0:
  - cnt and divisors hold; tick<=0.
  - No tick is lost or duplicated: counting resumes from the held value.
- sync=0, en=1, active_div==0:
  - tick<=0, cnt<=0, active_div<=pend_div.
  - A stopped channel therefore restarts on the edge after pend_div becomes nonzero.
- sync=0, en=1, cnt==active_div-1 (wrap):
  - cnt<=0, tick<=1, active_div<=pend_div.
- Otherwise (en=1): cnt<=cnt+1, tick<=0.
- Tick timing: tick is registered. First tick after reset or sync is high for the cycle following the N-th enabled edge. Subsequent ticks are exactly N enabled cycles apart.
- Writes:
  - When wr_en=1 and wr_ch<NUM_CH, pend_div[wr_ch]<=wr_div on that edge.
  - active_div switches only at a wrap, a sync or from the disabled state, so there are never short or long glitch periods.
  - A write coinciding with a wrap on the same channel: that wrap loads the old pend_div; the new value takes effect at the next wrap.
  - A write coinciding with sync: the sync loads the old pend_div; the new value applies at the next wrap.
  - wr_ch>=NUM_CH: no register changes; wr_err<=1 for one cycle. Otherwise wr_err<=0.
- Arithmetic:
  - cnt is CNT_W bits; the compare against active_div-1 is done at CNT_W width.
  - cnt never exceeds active_div-1, so there is no wrap-around overflow.
- Channels are fully independent; simultaneous ticks on several channels are legal.

Optional Feature:
- Macro: MULTI_TICK_GENERATOR_SQUARE_EN.
- When defined:
  - Adds output port sq [NUM_CH].
  - Each bit toggles on every edge where that channel's tick is set, giving a 50% square wave of period 2N.
  - Reset value 0; sync clears it to 0; it holds while en=0 or while the channel is disabled.
- When undefined: port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Test parameters: NUM_CH=2, CNT_W=8, DIV_INIT={8'd1, 8'd4}.
- Reset release, en=1 -> tick[0] high on cycles 4, 8, 12 (1 cycle wide); tick[1] high every cycle from cycle 1.
- Write ch0=6 at cycle 2 -> ticks at 4 (old period), then 10, 16 (new period).
- Write ch0=0 -> tick[0] stops after the next wrap. Write ch0=3 -> restart, first tick 4 cycles after the write edge.
- en low for 5 cycles mid-period at cnt=2 (ch0, N=4) -> no ticks while low; next tick 2 enabled cycles after en returns.
- sync pulse at cnt=3 (ch0) -> tick suppressed, next tick 4 cycles later. wr_ch=3 -> wr_err pulses 1 cycle, divisors unchanged.
- Assert rst asynchronously mid-tick (between edges) -> tick, wr_err (and sq if enabled) go 0 immediately; divisors return to DIV_INIT. With SQUARE_EN, ch0 N=4 -> sq[0] period 8, duty 50%.

Source files
------------

// File: rtl/multi_tick_generator_if.sv
// ============================================================================
// Module : multi_tick_generator_if
// Brief  : Control, write and tick bundle for multi_tick_generator.
//          The optional sq member is present when MULTI_TICK_GENERATOR_SQUARE_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface multi_tick_generator_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int CH_W   = (NUM_CH > 1 ? $clog2(NUM_CH) : 1)
);
    logic              en;
    logic              sync;
    logic              wr_en;
    logic [CH_W-1:0]   wr_ch;
    logic [CNT_W-1:0]  wr_div;
    logic [NUM_CH-1:0] tick;
    logic              wr_err;
`ifdef MULTI_TICK_GENERATOR_SQUARE_EN
    logic [NUM_CH-1:0] sq;
`endif

`ifdef MULTI_TICK_GENERATOR_SQUARE_EN
    modport master (output en, sync, wr_en, wr_ch, wr_div, input tick, wr_err, sq);
    modport slave  (input en, sync, wr_en, wr_ch, wr_div, output tick, wr_err, sq);
`else
    modport master (output en, sync, wr_en, wr_ch, wr_div, input tick, wr_err);
    modport slave  (input en, sync, wr_en, wr_ch, wr_div, output tick, wr_err);
`endif
endinterface

`default_nettype wire

// File: rtl/multi_tick_generator.sv
// ============================================================================
// Module : multi_tick_generator
// Brief  : NUM_CH independent programmable tick dividers with glitch-free
//          divisor reload. Optional MULTI_TICK_GENERATOR_SQUARE_EN adds sq.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multi_tick_generator #(
    parameter int                      NUM_CH   = 4,
    parameter int                      CNT_W    = 32,
    parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {32'd1_000_000, 32'd100_000,
                                                   32'd25_000, 32'd100_000_000},
    parameter int                      CH_W     = (NUM_CH > 1 ? $clog2(NUM_CH) : 1)
) (
    input  wire logic            clk,
    input  wire logic            rst,
    multi_tick_generator_if.slave bus
);

    logic [NUM_CH-1:0] w_tick;
    logic              w_ch_ok;
    logic              r_wr_err;
`ifdef MULTI_TICK_GENERATOR_SQUARE_EN
    logic [NUM_CH-1:0] w_sq;
`endif

    // Widen before comparing so power-of-two and odd channel counts behave alike
    assign w_ch_ok = ({{(32-CH_W){1'b0}}, bus.wr_ch} < 32'(NUM_CH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= bus.wr_en & ~w_ch_ok;
        end
    end

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] r_active;
            logic [CNT_W-1:0] r_pend;
            logic             r_tick;
            logic             w_wr_hit;
            logic             w_off;
            logic             w_wrap;

            assign w_wr_hit = bus.wr_en & w_ch_ok & (bus.wr_ch == CH_W'(i));
            assign w_off    = (r_active == '0);
            assign w_wrap   = (r_cnt == r_active - CNT_W'(1));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_pend <= DIV_INIT[i*CNT_W +: CNT_W];
                end else if (w_wr_hit) begin
                    r_pend <= bus.wr_div;
                end
            end

            // active only reloads at a period boundary, so no period is ever truncated
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt    <= '0;
                    r_active <= DIV_INIT[i*CNT_W +: CNT_W];
                    r_tick   <= 1'b0;
                end else if (bus.sync) begin
                    r_cnt    <= '0;
                    r_active <= r_pend;
                    r_tick   <= 1'b0;
                end else if (!bus.en) begin
                    r_tick   <= 1'b0;
                end else if (w_off) begin
                    r_cnt    <= '0;
                    r_active <= r_pend;
                    r_tick   <= 1'b0;
                end else if (w_wrap) begin
                    r_cnt    <= '0;
                    r_active <= r_pend;
                    r_tick   <= 1'b1;
                end else begin
                    r_cnt    <= r_cnt + CNT_W'(1);
                    r_tick   <= 1'b0;
                end
            end

            assign w_tick[i] = r_tick;

`ifdef MULTI_TICK_GENERATOR_SQUARE_EN
            logic r_sq;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sq <= 1'b0;
                end else if (bus.sync) begin
                    r_sq <= 1'b0;
                end else if (bus.en && !w_off && w_wrap) begin
                    r_sq <= ~r_sq;
                end
            end

            assign w_sq[i] = r_sq;
`endif
        end
    endgenerate

    assign bus.tick   = w_tick;
    assign bus.wr_err = r_wr_err;
`ifdef MULTI_TICK_GENERATOR_SQUARE_EN
    assign bus.sq     = w_sq;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multi_tick_generator.sv
// ============================================================================
// Module : tb_multi_tick_generator
// Brief  : Directed self-checking bench; 2-channel main DUT plus a 3-channel
//          DUT so that an out-of-range channel index is expressible.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multi_tick_generator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    multi_tick_generator_if #(.NUM_CH(2), .CNT_W(8)) bus ();
    multi_tick_generator_if #(.NUM_CH(3), .CNT_W(8)) bus3 ();

    multi_tick_generator #(.NUM_CH(2), .CNT_W(8), .DIV_INIT({8'd1, 8'd4})) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    multi_tick_generator #(.NUM_CH(3), .CNT_W(8), .DIV_INIT({8'd5, 8'd3, 8'd2})) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.en  = 1'b0; bus.sync  = 1'b0; bus.wr_en  = 1'b0; bus.wr_ch  = '0; bus.wr_div  = '0;
        bus3.en = 1'b0; bus3.sync = 1'b0; bus3.wr_en = 1'b0; bus3.wr_ch = '0; bus3.wr_div = '0;
    endtask

    // Reset is released between edges; the next rising edge is edge 1
    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        for (int k = 1; k <= 3; k++) begin
            step();
            n_cmp++;
            if (bus.tick !== 2'b00 || bus.wr_err !== 1'b0 || bus3.tick !== 3'b000 || bus3.wr_err !== 1'b0) begin
                n_bad++;
                $display("FAIL reset k=%0d: tick=%b err=%b tick3=%b err3=%b, required all 0",
                         k, bus.tick, bus.wr_err, bus3.tick, bus3.wr_err);
            end
            bus.en = 1'b1;
        end
    endtask

    task automatic test_basic();
        logic [1:0] e;
        do_reset();
        bus.en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            e = {1'b1, (k % 4 == 0)};
            n_cmp++;
            if (bus.tick !== e) begin
                n_bad++;
                $display("FAIL basic k=%0d: tick=%b required %b", k, bus.tick, e);
            end
        end
    endtask

    task automatic test_div_write();
        logic e;
        do_reset();
        bus.en = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            step();
            e = (k == 4 || k == 10 || k == 16);
            n_cmp++;
            if (bus.tick[0] !== e || bus.wr_err !== 1'b0) begin
                n_bad++;
                $display("FAIL div_write k=%0d: tick0=%b err=%b required %b 0", k, bus.tick[0], bus.wr_err, e);
            end
            if (k == 1) begin bus.wr_en = 1'b1; bus.wr_ch = 1'b0; bus.wr_div = 8'd6; end
            if (k == 2) bus.wr_en = 1'b0;
        end
    endtask

    task automatic test_disable();
        logic e;
        do_reset();
        bus.en = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            step();
            e = (k == 4 || k == 17 || k == 20 || k == 23);
            n_cmp++;
            if (bus.tick[0] !== e) begin
                n_bad++;
                $display("FAIL disable k=%0d: tick0=%b required %b", k, bus.tick[0], e);
            end
            if (k == 1)  begin bus.wr_en = 1'b1; bus.wr_ch = 1'b0; bus.wr_div = 8'd0; end
            if (k == 12) begin bus.wr_en = 1'b1; bus.wr_ch = 1'b0; bus.wr_div = 8'd3; end
            if (k == 2 || k == 13) bus.wr_en = 1'b0;
        end
    endtask

    task automatic test_en_pause();
        logic [1:0] e;
        do_reset();
        bus.en = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            e = {!(k >= 3 && k <= 7), (k == 9)};
            n_cmp++;
            if (bus.tick !== e) begin
                n_bad++;
                $display("FAIL en_pause k=%0d: tick=%b required %b", k, bus.tick, e);
            end
            if (k == 2) bus.en = 1'b0;
            if (k == 7) bus.en = 1'b1;
        end
    endtask

    task automatic test_sync();
        logic [1:0] e;
        do_reset();
        bus.en = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            step();
            e = {(k != 4 && k != 10), (k == 8 || k == 14 || k == 16 || k == 18)};
            n_cmp++;
            if (bus.tick !== e) begin
                n_bad++;
                $display("FAIL sync k=%0d: tick=%b required %b", k, bus.tick, e);
            end
            if (k == 3) bus.sync = 1'b1;
            if (k == 4) bus.sync = 1'b0;
            if (k == 9) begin bus.sync = 1'b1; bus.wr_en = 1'b1; bus.wr_ch = 1'b0; bus.wr_div = 8'd2; end
            if (k == 10) begin bus.sync = 1'b0; bus.wr_en = 1'b0; end
        end
    endtask

    // Write lands on the wrap edge: one more old period before the new divisor
    task automatic test_back_to_back();
        logic e;
        do_reset();
        bus.en = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step();
            e = (k == 4 || k == 8 || k == 10 || k == 12 || k == 14);
            n_cmp++;
            if (bus.tick[0] !== e) begin
                n_bad++;
                $display("FAIL back_to_back k=%0d: tick0=%b required %b", k, bus.tick[0], e);
            end
            if (k == 3) begin bus.wr_en = 1'b1; bus.wr_ch = 1'b0; bus.wr_div = 8'd2; end
            if (k == 4) bus.wr_en = 1'b0;
        end
    endtask

    task automatic test_wr_err();
        logic [2:0] e;
        logic       ee;
        do_reset();
        bus3.en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            e  = {(k % 5 == 0), (k % 3 == 0), (k % 2 == 0)};
            ee = (k == 2);
            n_cmp++;
            if (bus3.tick !== e || bus3.wr_err !== ee) begin
                n_bad++;
                $display("FAIL wr_err k=%0d: tick3=%b err=%b required %b %b", k, bus3.tick, bus3.wr_err, e, ee);
            end
            if (k == 1) begin bus3.wr_en = 1'b1; bus3.wr_ch = 2'd3; bus3.wr_div = 8'd1; end
            if (k == 5) begin bus3.wr_en = 1'b1; bus3.wr_ch = 2'd2; bus3.wr_div = 8'd5; end
            if (k == 2 || k == 6) bus3.wr_en = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        logic e;
        do_reset();
        bus.en  = 1'b1;
        bus3.en = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            if (k == 1) begin bus.wr_en = 1'b1; bus.wr_ch = 1'b0; bus.wr_div = 8'd6; end
            if (k == 2) bus.wr_en = 1'b0;
        end
        bus3.wr_en = 1'b1; bus3.wr_ch = 2'd3;
        step();
        n_cmp++;
        if (bus3.wr_err !== 1'b1 || bus.tick[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL async_pre: err3=%b tick1=%b required 1 1", bus3.wr_err, bus.tick[1]);
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.tick !== 2'b00 || bus3.tick !== 3'b000 || bus3.wr_err !== 1'b0) begin
            n_bad++;
            $display("FAIL async_rst: tick=%b tick3=%b err3=%b required 00 000 0", bus.tick, bus3.tick, bus3.wr_err);
        end
`ifdef MULTI_TICK_GENERATOR_SQUARE_EN
        n_cmp++;
        if (bus.sq !== 2'b00) begin
            n_bad++;
            $display("FAIL async_sq: sq=%b required 00", bus.sq);
        end
`endif
        idle_inputs();
        #1 rst = 1'b0;
        bus.en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            e = (k == 4 || k == 8);
            n_cmp++;
            if (bus.tick[0] !== e) begin
                n_bad++;
                $display("FAIL async_post k=%0d: tick0=%b required %b", k, bus.tick[0], e);
            end
        end
    endtask

`ifdef MULTI_TICK_GENERATOR_SQUARE_EN
    task automatic test_square();
        logic [1:0] e;
        do_reset();
        bus.en = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            e = {(k % 2 == 1), ((k / 4) % 2 == 1)};
            n_cmp++;
            if (bus.sq !== e) begin
                n_bad++;
                $display("FAIL square k=%0d: sq=%b required %b", k, bus.sq, e);
            end
        end
    endtask
`endif

    initial begin
        idle_inputs();
        test_reset();
        test_basic();
        test_div_write();
        test_disable();
        test_en_pause();
        test_sync();
        test_back_to_back();
        test_wr_err();
        test_async_reset();
`ifdef MULTI_TICK_GENERATOR_SQUARE_EN
        test_square();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
